// File: rtl/param_updown_counter_if.sv
// Control/status bundle for param_updown_counter: the master drives the
// controls and the slave returns count, tc, busy, done and snap.
interface param_updown_counter_if #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
);
  logic              en;
  logic              load;
  logic [WIDTH-1:0]  load_val;
  logic              up;
  logic [STEP_W-1:0] step;
  logic [WIDTH-1:0]  limit;
  logic [1:0]        mode;
  logic              start;
  logic              stop;
  logic              oe;
  logic              capture;
  logic [WIDTH-1:0]  count;
  logic              tc;
  logic              busy;
  logic              done;
  logic [WIDTH-1:0]  snap;

  modport master (
    output en, load, load_val, up, step, limit, mode, start, stop, oe, capture,
    input  count, tc, busy, done, snap
  );

  modport slave (
    input  en, load, load_val, up, step, limit, mode, start, stop, oe, capture,
    output count, tc, busy, done, snap
  );
endinterface

// File: rtl/param_updown_counter.sv
// Up/down counter with wrap, modulo and one-shot modes plus an IDLE/RUN/DONE FSM.
// Optional snapshot register is enabled by defining PCNT_SNAPSHOT_EN.
module param_updown_counter #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
) (
  input  logic clk,
  input  logic rst_n,
  param_updown_counter_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d, stepped;
  logic             tc_q, tc_d, busy_q, done_q;
  logic             wrap, hit, count_now;
  logic [WIDTH:0]   ext_cnt, ext_step, ext_lim, sum, diff, mod_up, mod_dn;

  // All arithmetic is one bit wider so limit = all-ones never loses a carry.
  always_comb begin
    ext_cnt  = {1'b0, cnt_q};
    ext_step = {{(WIDTH+1-STEP_W){1'b0}}, bus.step};
    ext_lim  = {1'b0, bus.limit};
    sum      = ext_cnt + ext_step;
    diff     = ext_cnt - ext_step;
    mod_up   = sum - ext_lim - ONE;
    mod_dn   = ext_cnt + ext_lim + ONE - ext_step;
    stepped  = cnt_q;
    wrap     = 1'b0;
    hit      = 1'b0;
    if (bus.step != '0) begin
      case (bus.mode)
        2'b01: begin
          if (cnt_q > bus.limit) begin
            stepped = '0;
            wrap    = 1'b1;
          end else if (bus.up) begin
            if (sum > ext_lim) begin
              stepped = mod_up[WIDTH-1:0];
              wrap    = 1'b1;
            end else begin
              stepped = sum[WIDTH-1:0];
            end
          end else begin
            if (ext_cnt < ext_step) begin
              stepped = mod_dn[WIDTH-1:0];
              wrap    = 1'b1;
            end else begin
              stepped = diff[WIDTH-1:0];
            end
          end
        end
        2'b10: begin
          if (bus.up) begin
            if (sum >= ext_lim) begin
              stepped = bus.limit;
              hit     = 1'b1;
            end else begin
              stepped = sum[WIDTH-1:0];
            end
          end else begin
            if (ext_cnt <= ext_step) begin
              stepped = '0;
              hit     = 1'b1;
            end else begin
              stepped = diff[WIDTH-1:0];
            end
          end
        end
        default: begin
          stepped = bus.up ? sum[WIDTH-1:0] : diff[WIDTH-1:0];
          wrap    = bus.up ? sum[WIDTH]     : diff[WIDTH];
        end
      endcase
    end
  end

  // Load owns the count register; stop/start still steer the FSM alongside it.
  always_comb begin
    count_now = (state_q == S_RUN) && bus.en && !bus.load && !bus.stop;
    cnt_d     = bus.load ? bus.load_val : (count_now ? stepped : cnt_q);
    tc_d      = count_now && (wrap || hit);
    state_d   = state_q;
    if (bus.stop && state_q != S_IDLE)       state_d = S_IDLE;
    else if (bus.start && state_q != S_RUN)  state_d = S_RUN;
    else if (count_now && hit)               state_d = S_DONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      tc_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tc_q    <= tc_d;
      busy_q  <= (state_d == S_RUN);
      done_q  <= (state_d == S_DONE);
    end
  end

`ifdef PCNT_SNAPSHOT_EN
  logic [WIDTH-1:0] snap_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           snap_q <= '0;
    else if (bus.capture) snap_q <= cnt_d;
  end

  assign bus.snap = snap_q;
  logic unused_bits;
  assign unused_bits = ^{mod_up[WIDTH], mod_dn[WIDTH]};
`else
  assign bus.snap = '0;
  logic unused_bits;
  assign unused_bits = ^{mod_up[WIDTH], mod_dn[WIDTH], bus.capture};
`endif

  assign bus.count = bus.oe ? cnt_q : '0;
  assign bus.tc    = tc_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_param_updown_counter.sv
// Directed scenarios followed by random traffic, all checked against an
// arithmetic reference model of the counter rules (WIDTH=8, STEP_W=4).
module tb_param_updown_counter;
  localparam int W    = 8;
  localparam int SW   = 4;
  localparam int MAXV = 1 << W;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  // model: state 0 = IDLE, 1 = RUN, 2 = DONE
  int m_cnt, m_st, m_snap;
  bit m_tc;

  param_updown_counter_if #(.WIDTH(W), .STEP_W(SW)) bus ();

  param_updown_counter #(.WIDTH(W), .STEP_W(SW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_st = 0; m_snap = 0; m_tc = 0;
  endtask

  task automatic model_step();
    int c, s, l, nv;
    bit wr, hit, cnow;
    c = m_cnt; s = int'(bus.step); l = int'(bus.limit);
    nv = c; wr = 0; hit = 0;
    cnow = (m_st == 1) && bus.en && !bus.load && !bus.stop;
    if (s != 0) begin
      if (bus.mode == 2'b01) begin
        if (c > l)            begin nv = 0; wr = 1; end
        else if (bus.up)      begin if (c + s > l) begin nv = c + s - l - 1; wr = 1; end else nv = c + s; end
        else                  begin if (c < s) begin nv = c + l + 1 - s; wr = 1; end else nv = c - s; end
      end else if (bus.mode == 2'b10) begin
        if (bus.up) begin if (c + s >= l) begin nv = l; hit = 1; end else nv = c + s; end
        else        begin if (c <= s)     begin nv = 0; hit = 1; end else nv = c - s; end
      end else begin
        if (bus.up) begin nv = (c + s) % MAXV; wr = (c + s >= MAXV); end
        else        begin nv = (c - s + MAXV) % MAXV; wr = (c < s); end
      end
    end
    if (bus.stop && m_st != 0)       m_st = 0;
    else if (bus.start && m_st != 1) m_st = 1;
    else if (cnow && hit)            m_st = 2;
    m_tc  = cnow && (wr || hit);
    m_cnt = bus.load ? int'(bus.load_val) : (cnow ? nv : c);
`ifdef PCNT_SNAPSHOT_EN
    if (bus.capture) m_snap = m_cnt;
`endif
  endtask

  task automatic check_all(input string tag);
    check({tag, ".count"}, 32'(bus.count), bus.oe ? 32'(m_cnt) : 32'd0);
    check({tag, ".tc"},    32'(bus.tc),    32'(m_tc));
    check({tag, ".busy"},  32'(bus.busy),  32'(m_st == 1));
    check({tag, ".done"},  32'(bus.done),  32'(m_st == 2));
    check({tag, ".snap"},  32'(bus.snap),  32'(m_snap));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.en = 0; bus.load = 0; bus.load_val = '0; bus.up = 1; bus.step = '0;
    bus.limit = '0; bus.mode = 2'b00; bus.start = 0; bus.stop = 0;
    bus.oe = 1; bus.capture = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    check("reset.count_const", 32'(bus.count), 32'd0);
    rst_n = 1'b1;

    // wrap mode up by 3 across the top
    bus.mode = 2'b00; bus.up = 1; bus.step = 3; bus.en = 1;
    bus.load = 1; bus.load_val = 8'd254; bus.start = 1;
    tick("wrap0");
    check("wrap0.c", 32'(bus.count), 32'd254);
    bus.load = 0; bus.start = 0;
    tick("wrap1");
    check("wrap1.c", 32'(bus.count), 32'd1);
    check("wrap1.tc", 32'(bus.tc), 32'd1);
    tick("wrap2");
    check("wrap2.c", 32'(bus.count), 32'd4);
    check("wrap2.tc", 32'(bus.tc), 32'd0);

    // modulo 10 both directions
    bus.mode = 2'b01; bus.limit = 8'd9; bus.step = 4;
    bus.load = 1; bus.load_val = 8'd8;
    tick("mod0");
    bus.load = 0;
    tick("mod1");
    check("mod1.c", 32'(bus.count), 32'd2);
    check("mod1.tc", 32'(bus.tc), 32'd1);
    bus.up = 0;
    tick("mod2");
    check("mod2.c", 32'(bus.count), 32'd8);
    check("mod2.tc", 32'(bus.tc), 32'd1);

    // one-shot up to 20
    bus.stop = 1; bus.load = 1; bus.load_val = 8'd0;
    bus.mode = 2'b10; bus.limit = 8'd20; bus.step = 7; bus.up = 1;
    tick("os_stop");
    bus.stop = 0; bus.load = 0; bus.start = 1;
    tick("os_start");
    bus.start = 0;
    tick("os7");
    check("os7.c", 32'(bus.count), 32'd7);
    tick("os14");
    tick("os20");
    check("os20.c", 32'(bus.count), 32'd20);
    check("os20.done", 32'(bus.done), 32'd1);
    check("os20.busy", 32'(bus.busy), 32'd0);
    tick("os_hold");
    check("os_hold.c", 32'(bus.count), 32'd20);
    bus.start = 1; bus.mode = 2'b00; bus.step = 1;
    tick("os_restart");
    check("os_restart.busy", 32'(bus.busy), 32'd1);
    bus.start = 0;
    tick("run21");

    // load + stop together in RUN
    bus.load = 1; bus.load_val = 8'h3C; bus.stop = 1;
    tick("ldstop");
    check("ldstop.c", 32'(bus.count), 32'h3C);
    check("ldstop.busy", 32'(bus.busy), 32'd0);
    check("ldstop.tc", 32'(bus.tc), 32'd0);
    bus.stop = 0;

    // snapshot on a 5 -> 6 count
    bus.load_val = 8'd5; bus.start = 1;
    tick("snap_ld");
    bus.load = 0; bus.start = 0; bus.capture = 1;
    tick("snap");
`ifdef PCNT_SNAPSHOT_EN
    check("snap.v", 32'(bus.snap), 32'd6);
`else
    check("snap.v", 32'(bus.snap), 32'd0);
`endif
    bus.capture = 0;

    // async reset mid-RUN at 0x55
    bus.en = 0; bus.load = 1; bus.load_val = 8'h55;
    tick("pre_rst");
    bus.load = 0;
    tick("hold55");
    check("hold55.c", 32'(bus.count), 32'h55);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    check("async_rst.c", 32'(bus.count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.load = 1; bus.load_val = 8'hA7; bus.oe = 0;
    tick("oe_off");
    check("oe_off.c", 32'(bus.count), 32'd0);
    bus.oe = 1;
    #1;
    check("oe_on.c", 32'(bus.count), 32'hA7);
    bus.load = 0;

    // random traffic
    for (int i = 0; i < 400; i++) begin
      bus.en       = ($urandom % 4) != 0;
      bus.load     = ($urandom % 12) == 0;
      bus.load_val = 8'($urandom);
      bus.stop     = ($urandom % 16) == 0;
      bus.start    = ($urandom % 5) == 0;
      bus.up       = 1'($urandom);
      bus.mode     = 2'($urandom);
      bus.step     = 4'($urandom);
      bus.limit    = ($urandom % 2) ? 8'($urandom_range(0, 31)) : 8'($urandom);
      bus.oe       = ($urandom % 8) != 0;
      bus.capture  = ($urandom % 4) == 0;
      tick("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/param_updown_counter.md
PARAM_UPDOWN_COUNTER -- requirements
Module: param_updown_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, counter width (legal range 4..32).
REQ-002 SHALL have parameter STEP_W, default 4, step-input width (legal range 1..WIDTH).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port en  input  1  count enable; when low, the count holds.
REQ-006 SHALL have port load  input  1  synchronous load strobe.
REQ-007 SHALL have port load_val  input  WIDTH  value written on load.
REQ-008 SHALL have port up  input  1  direction; 1 = up, 0 = down.
REQ-009 SHALL have port step  input  STEP_W  increment magnitude, unsigned.
REQ-010 SHALL have port limit  input  WIDTH  modulo / one-shot terminal value.
REQ-011 SHALL have port mode  input  2  00 wrap 2^WIDTH, 01 modulo limit+1, 10 one-shot, 11 reserved (behaves as 00).
REQ-012 SHALL have port start  input  1  IDLE/DONE to RUN request.
REQ-013 SHALL have port stop  input  1  return to IDLE, count held.
REQ-014 SHALL have port oe  input  1  output enable.
REQ-015 SHALL have port count  output  WIDTH  counter value when oe=1, else all zeros.
REQ-016 SHALL have port tc  output  1  one-cycle terminal/wrap pulse, registered.
REQ-017 SHALL have port busy  output  1  high in RUN.
REQ-018 SHALL have port done  output  1  high in DONE.
REQ-019 SHALL have ports capture  input  1  and snap  output  WIDTH  (see Configuration).

Function
REQ-020 SHALL implement FSM IDLE, RUN, DONE; transitions: IDLE-start->RUN, RUN-stop->IDLE, RUN-one-shot terminal->DONE, DONE-start->RUN, DONE-stop->IDLE.
REQ-021 SHALL apply per-cycle priority: load > stop > start > count; load is legal in any state, does not change state, and suppresses tc.
REQ-022 SHALL update the count only in RUN with en=1 and load=0; start takes effect the cycle after it is sampled (first count one cycle after the RUN entry edge).
REQ-023 SHALL, in mode 00, compute count±step modulo 2^WIDTH and pulse tc when the result wraps past the all-ones/zero boundary.
REQ-024 SHALL, in mode 01 up, produce count+step-limit-1 when count+step>limit, else count+step; down: count+limit+1-step when count<step, else count-step; tc pulses on each wrap.
REQ-025 SHALL, in mode 01 with count>limit, set the next counted value to 0 in either direction and pulse tc.
REQ-026 SHALL, in mode 10 up, saturate at limit; down, saturate at 0; on reaching the target, pulse tc and enter DONE in the same edge.
REQ-027 SHALL treat step=0 as hold: no change, no tc, no transition to DONE.
REQ-028 SHALL compute intermediate sums at WIDTH+1 bits so no carry is lost for any limit up to 2^WIDTH-1.
REQ-029 SHALL update count, tc, busy and done registers on clk edges only; the oe gating of count is combinational.

Reset
REQ-030 SHALL, on rst_n low at any time including mid-RUN, immediately force count register=0, tc=0, busy=0, done=0, snap=0, state=IDLE.
REQ-031 SHALL resume normal operation on the first rising clk edge after rst_n deasserts; no input is sampled while rst_n is low.

Configuration
REQ-032 SHALL, with macro PCNT_SNAPSHOT_EN defined, copy the counter register into snap on a clk edge where capture=1, independent of oe and state, taking the post-update value when a count coincides.
REQ-033 SHALL, without PCNT_SNAPSHOT_EN, tie snap to 0, ignore capture and implement no snapshot register.

Verification (WIDTH=8, STEP_W=4)
REQ-034 SHALL cover: mode 00, up, step=3, load 254, start -> count 254, 1, 4; tc high exactly one cycle with count=1.
REQ-035 SHALL cover: mode 01, limit=9, up, step=4, load 8 -> next 2 with tc; down from 2 with step 4 -> 8 with tc.
REQ-036 SHALL cover: mode 10, limit=20, up, step=7, from 0 -> 7, 14, 20; done=1 and busy=0 on reaching 20; holds at 20; start restarts RUN.
REQ-037 SHALL cover: load and stop asserted together in RUN -> count=load_val, state IDLE, tc=0.
REQ-038 SHALL cover: rst_n pulled low mid-RUN at count 0x55 between edges -> count, busy, tc, snap read 0 immediately; oe=0 -> count port reads 0x00.
REQ-039 SHALL cover: with PCNT_SNAPSHOT_EN, capture on the edge where count goes 5->6 -> snap=6; without the macro, snap stays 0.
